// File: rtl/div_if.sv
// Start/busy/done handshake and operand/result bus between the execute stage and the divider.
interface div_if #(
    parameter int unsigned N = 16
) ();
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div.sv
// Sequential restoring unsigned divider: one quotient bit per clock, N-cycle latency,
// divide-by-zero finishes immediately with quotient all ones and remainder = dividend.
module div #(
    parameter int unsigned N = 16
) (
    input  logic  clk,
    input  logic  rst_n,
    div_if.slave  bus
);
    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  qreg_q, qreg_d;
    logic [N-1:0]  dvsr_q, dvsr_d;
    logic [N-1:0]  part_q, part_d;
    logic [N-1:0]  quot_q, quot_d;
    logic [N-1:0]  rem_q, rem_d;
    logic          dbz_q, dbz_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // Trial value is N+1 bits; the stored partial is always below the divisor, so N bits suffice to hold it.
    logic [N:0]    trial_c;
    logic [N-1:0]  diff_c;
    logic          ge_c;

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        qreg_d  = qreg_q;
        dvsr_d  = dvsr_q;
        part_d  = part_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        trial_c = {part_q, qreg_q[N-1]};
        ge_c    = (trial_c >= {1'b0, dvsr_q});
        diff_c  = trial_c[N-1:0] - dvsr_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.divisor != '0) begin
                        qreg_d  = bus.dividend;
                        dvsr_d  = bus.divisor;
                        part_d  = '0;
                        cnt_d   = CW'(N);
                        state_d = RUN;
                    end else begin
                        quot_d  = '1;
                        rem_d   = bus.dividend;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                part_d = ge_c ? diff_c : trial_c[N-1:0];
                qreg_d = {qreg_q[N-2:0], ge_c};
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    quot_d  = {qreg_q[N-2:0], ge_c};
                    rem_d   = ge_c ? diff_c : trial_c[N-1:0];
                    dbz_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            qreg_q  <= '0;
            dvsr_q  <= '0;
            part_q  <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            qreg_q  <= qreg_d;
            dvsr_q  <= dvsr_d;
            part_q  <= part_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_div.sv
// Randomized and directed checks of the divider against plain-arithmetic expectations.
module tb_div;
    localparam int unsigned N = 16;

    logic clk;
    logic rst_n;
    int   errs;
    int   checks;

    logic [N-1:0] exp_q;
    logic [N-1:0] exp_r;
    logic         exp_z;

    div_if #(.N(N)) bus ();

    div #(.N(N)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #20ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_q"},    32'(bus.quotient), 32'd0);
        chk({tag, "_r"},    32'(bus.remainder), 32'd0);
        chk({tag, "_z"},    32'(bus.div_by_zero), 32'd0);
    endtask

    // Issue one divide, optionally re-pulsing start (50/5) after pulse_at RUN cycles.
    task automatic run_div(input logic [N-1:0] a, input logic [N-1:0] d, input int pulse_at);
        int           cyc;
        logic [N-1:0] mq;
        logic [N-1:0] mr;
        logic         mz;
        if (d == '0) begin
            mq = '1;
            mr = a;
            mz = 1'b1;
        end else begin
            mq = a / d;
            mr = a % d;
            mz = 1'b0;
        end

        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = d;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.dividend = N'($urandom);
        bus.divisor  = N'($urandom);
        chk("busy_at_accept", 32'(bus.busy), 32'd1);

        cyc = 0;
        while (!bus.done && cyc < 40) begin
            chk("hold_q_run", 32'(bus.quotient), 32'(exp_q));
            chk("hold_r_run", 32'(bus.remainder), 32'(exp_r));
            if (cyc == pulse_at) begin
                bus.start    = 1'b1;
                bus.dividend = N'(50);
                bus.divisor  = N'(5);
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            cyc++;
        end

        chk("latency", 32'(cyc), (d == '0) ? 32'd0 : 32'(N));
        chk("quotient", 32'(bus.quotient), 32'(mq));
        chk("remainder", 32'(bus.remainder), 32'(mr));
        chk("div_by_zero", 32'(bus.div_by_zero), 32'(mz));
        chk("busy_with_done", 32'(bus.busy), 32'd1);
        if (d != '0) begin
            chk("identity", 32'(bus.quotient) * 32'(d) + 32'(bus.remainder), 32'(a));
            chk("rem_lt_div", 32'(bus.remainder < d), 32'd1);
        end
        exp_q = mq;
        exp_r = mr;
        exp_z = mz;

        @(posedge clk); #1;
        chk("done_pulse_width", 32'(bus.done), 32'd0);
        chk("busy_idle", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        errs         = 0;
        checks       = 0;
        exp_q        = '0;
        exp_r        = '0;
        exp_z        = 1'b0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        rst_n = 1'b1;

        run_div(N'(100), N'(7), -1);
        run_div(N'(16'hFFFF), N'(1), -1);
        run_div(N'(16'hFFFF), N'(16'hFFFF), -1);
        run_div(N'(3), N'(10), -1);
        run_div(N'(5), N'(0), -1);
        run_div(N'(9), N'(3), -1);

        // Start re-pulsed mid-divide must be ignored; results then hold through idle.
        run_div(N'(1000), N'(3), 3);
        repeat (3) begin
            @(posedge clk); #1;
            chk("hold_q_idle", 32'(bus.quotient), 32'd333);
            chk("hold_r_idle", 32'(bus.remainder), 32'd1);
            chk("idle_no_done", 32'(bus.done), 32'd0);
        end

        // Asynchronous reset in the middle of a divide.
        bus.start    = 1'b1;
        bus.dividend = N'(60000);
        bus.divisor  = N'(7);
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        chk("busy_mid_run", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("async_reset");
        exp_q = '0;
        exp_r = '0;
        exp_z = 1'b0;
        @(posedge clk); #1;
        chk_outputs_zero("reset_held");
        rst_n = 1'b1;
        run_div(N'(60000), N'(7), -1);

        for (int i = 0; i < 1500; i++) begin
            logic [N-1:0] a;
            logic [N-1:0] d;
            a = N'($urandom);
            case ($urandom_range(0, 3))
                0:       d = N'($urandom_range(1, 15));
                1:       d = N'($urandom_range(1, 255));
                default: d = N'($urandom_range(1, (1 << N) - 1));
            endcase
            run_div(a, d, -1);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
